// File: rtl/instr_fetch.sv
// Instruction fetch stage: serially loaded program buffer issued one word per cycle
// to decode, with stall hold, NOP fill and a done flag once the program is exhausted.
module instr_fetch #(
  parameter int             DEPTH = 64,
  parameter int             IW    = 25,
  parameter logic [IW-1:0]  NOP   = 25'h1800000,
  localparam int            AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic          stall,
  output logic [IW-1:0] instructionIF,
  output logic          valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic          lastIssue;
  logic          empty;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign lastIssue = ({1'b0, pc} == count - (AW+1)'(1));

  // start always beats load_en; RUN never writes the buffer.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = '0;
    if (!reset && load_en && !start) begin
      case (state)
        IDLE: if (!full) begin
          wrEn   = 1'b1;
          wrAddr = count[AW-1:0];
        end
        DONE: begin
          wrEn   = 1'b1;
          wrAddr = '0;
        end
        default: ;
      endcase
    end
  end

  // Buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      instructionIF <= NOP;
      valid         <= 1'b0;
      pc            <= '0;
      count         <= '0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc <= '0;
            if (empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else if (load_en && !full) begin
            count <= count + (AW+1)'(1);
          end
        end
        RUN: begin
          if (!stall) begin
            instructionIF <= mem[pc];
            valid         <= 1'b1;
            pc            <= pc + AW'(1);
            if (lastIssue) state <= DONE;
          end
        end
        DONE: begin
          instructionIF <= NOP;
          valid         <= 1'b0;
          done          <= 1'b1;
          if (start) begin
            // An empty program has nothing to re-issue, so stay finished.
            if (!empty) begin
              done  <= 1'b0;
              pc    <= '0;
              state <= RUN;
            end
          end else if (load_en) begin
            count <= (AW+1)'(1);
            done  <= 1'b0;
            pc    <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for load/issue/stall/restart/reload
// plus hand sequences for full buffer, empty start priority and mid-run reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [24:0] load_data;
  logic        start;
  logic        stall;
  logic [24:0] instructionIF;
  logic        valid;
  logic [5:0]  pc;
  logic [6:0]  count;
  logic        full;
  logic        done;

  localparam logic [24:0] NOPW = 25'h1800000;

  instr_fetch dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .start(start), .stall(stall), .instructionIF(instructionIF), .valid(valid),
    .pc(pc), .count(count), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld;
    logic [24:0] data;
    logic        st;
    logic        sl;
    logic [24:0] eInstr;
    logic        eValid;
    logic [5:0]  ePc;
    logic [6:0]  eCount;
    logic        eDone;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic ld, logic [24:0] data, logic st, logic sl,
                              logic [24:0] eI, logic eV, logic [5:0] eP,
                              logic [6:0] eC, logic eD);
    vec_t v;
    v.ld = ld; v.data = data; v.st = st; v.sl = sl;
    v.eInstr = eI; v.eValid = eV; v.ePc = eP; v.eCount = eC; v.eDone = eD;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkAll(string tag, logic [24:0] eI, logic eV, logic [5:0] eP,
                        logic [6:0] eC, logic eD, logic eF);
    chk({tag, ".instr"}, 32'(instructionIF), 32'(eI));
    chk({tag, ".valid"}, 32'(valid), 32'(eV));
    chk({tag, ".pc"},    32'(pc), 32'(eP));
    chk({tag, ".count"}, 32'(count), 32'(eC));
    chk({tag, ".done"},  32'(done), 32'(eD));
    chk({tag, ".full"},  32'(full), 32'(eF));
  endtask

  // Drive inputs mid-cycle, then sample 1 time unit after the rising edge.
  task automatic step(logic ld, logic [24:0] data, logic st, logic sl);
    @(negedge clk);
    load_en = ld; load_data = data; start = st; stall = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_en = 1'($urandom); load_data = 25'($urandom);
      start = 1'($urandom); stall = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0; load_en = 0; start = 0; stall = 0; load_data = '0;
  endtask

  initial begin
    reset = 1'b1; load_en = 0; load_data = '0; start = 0; stall = 0;

    // ld, data, start, stall | instr, valid, pc, count, done
    tbl[0]  = mk(1, 25'h184b02d, 0, 0, NOPW,        0, 0, 1, 0);
    tbl[1]  = mk(1, 25'h0000001, 0, 0, NOPW,        0, 0, 2, 0);
    tbl[2]  = mk(1, 25'h1ffffff, 0, 0, NOPW,        0, 0, 3, 0);
    tbl[3]  = mk(0, 25'h0,       1, 0, NOPW,        0, 0, 3, 0);
    tbl[4]  = mk(0, 25'h0,       0, 0, 25'h184b02d, 1, 1, 3, 0);
    tbl[5]  = mk(0, 25'h0,       0, 0, 25'h0000001, 1, 2, 3, 0);
    tbl[6]  = mk(0, 25'h0,       0, 0, 25'h1ffffff, 1, 3, 3, 0);
    tbl[7]  = mk(0, 25'h0,       0, 0, NOPW,        0, 3, 3, 1);
    tbl[8]  = mk(0, 25'h0,       0, 1, NOPW,        0, 3, 3, 1);
    tbl[9]  = mk(0, 25'h0,       1, 0, NOPW,        0, 0, 3, 0);
    tbl[10] = mk(1, 25'h1555555, 0, 0, 25'h184b02d, 1, 1, 3, 0);
    tbl[11] = mk(0, 25'h0,       0, 0, 25'h0000001, 1, 2, 3, 0);
    tbl[12] = mk(0, 25'h0,       0, 1, 25'h0000001, 1, 2, 3, 0);
    tbl[13] = mk(0, 25'h0,       1, 1, 25'h0000001, 1, 2, 3, 0);
    tbl[14] = mk(0, 25'h0,       0, 1, 25'h0000001, 1, 2, 3, 0);
    tbl[15] = mk(0, 25'h0,       0, 0, 25'h1ffffff, 1, 3, 3, 0);
    tbl[16] = mk(0, 25'h0,       0, 0, NOPW,        0, 3, 3, 1);
    tbl[17] = mk(1, 25'h0abcdef, 0, 0, NOPW,        0, 0, 1, 0);
    tbl[18] = mk(0, 25'h0,       1, 0, NOPW,        0, 0, 1, 0);
    tbl[19] = mk(0, 25'h0,       0, 0, 25'h0abcdef, 1, 1, 1, 0);
    tbl[20] = mk(0, 25'h0,       0, 0, NOPW,        0, 1, 1, 1);
    tbl[21] = mk(0, 25'h0,       0, 1, NOPW,        0, 1, 1, 1);

    // Reset defaults under random inputs
    doReset();
    chkAll("reset", NOPW, 0, 0, 0, 0, 0);

    // Basic issue, restart with stall, reload
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].ld, tbl[i].data, tbl[i].st, tbl[i].sl);
      chkAll($sformatf("vec%0d", i), tbl[i].eInstr, tbl[i].eValid,
             tbl[i].ePc, tbl[i].eCount, tbl[i].eDone, 1'b0);
    end

    // Full buffer: 64 words, dropped 65th, wrap of pc at completion
    doReset();
    for (int i = 0; i < 64; i++) step(1, 25'(i), 0, 0);
    chkAll("fill64", NOPW, 0, 0, 64, 0, 1);
    step(1, 25'h1555555, 0, 0);
    chkAll("fill65", NOPW, 0, 0, 64, 0, 1);
    step(0, 25'h0, 1, 0);
    for (int k = 0; k < 64; k++) begin
      step(0, 25'h0, 0, 0);
      chkAll($sformatf("full.issue%0d", k), 25'(k), 1, 6'(k + 1), 64, 0, 1);
    end
    step(0, 25'h0, 0, 0);
    chkAll("full.done", NOPW, 0, 0, 64, 1, 1);

    // Empty start goes straight to done; start beats load_en in DONE
    doReset();
    step(0, 25'h0, 1, 0);
    chkAll("empty.start", NOPW, 0, 0, 0, 1, 0);
    step(1, 25'h0abcdef, 1, 0);
    chkAll("empty.prio", NOPW, 0, 0, 0, 1, 0);
    step(0, 25'h0, 0, 0);
    chkAll("empty.hold", NOPW, 0, 0, 0, 1, 0);

    // Mid-run reset clears count and nothing is issued afterwards
    doReset();
    step(1, 25'h0000123, 0, 0);
    step(1, 25'h0000456, 0, 0);
    step(0, 25'h0, 1, 0);
    step(0, 25'h0, 0, 0);
    chkAll("mid.issue0", 25'h0000123, 1, 1, 2, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chkAll("mid.reset", NOPW, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 25'h0, 0, 0);
    chkAll("mid.after", NOPW, 0, 0, 0, 0, 0);
    step(0, 25'h0, 1, 0);
    chkAll("mid.restart", NOPW, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the pipelined SIMD unit: holds a program of 25-bit instructions in an internal buffer and issues one per cycle on `instructionIF` to the decode stage. The bench or host loads the buffer serially. `start` launches issue from address 0. Decode back-pressure is honoured through `stall`. When the program is exhausted, the stage emits NOPs and flags `done`.

## Interface
- `DEPTH`, 64: instruction buffer entries; power of two.
- `IW`, 25: instruction width.
- `NOP`, 25'h1800000: encoding issued when no valid instruction is present.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `load_en`  in  1: write `load_data` into the buffer at the next load slot.
- `load_data`  in  IW: instruction word to load.
- `start`  in  1: one-cycle pulse that begins issue from address 0.
- `stall`  in  1: hold the current issue; sampled only in RUN.
- `instructionIF`  out  IW: registered instruction to decode.
- `valid`  out  1: `instructionIF` holds a real program instruction.
- `pc`  out  log2(DEPTH): address of the next instruction to issue.
- `count`  out  log2(DEPTH)+1: number of loaded instructions.
- `full`  out  1: `count == DEPTH`; combinational from `count`.
- `done`  out  1: program fully issued.

## Operation
- States: IDLE, RUN, DONE. Reset moves to IDLE.
- Reset values:
  - `instructionIF` = NOP, `valid` = 0, `pc` = 0, `count` = 0, `done` = 0, `full` = 0.
  - Buffer contents are not cleared.
- IDLE:
  - `load_en` && !`full`: write `buf[count]` <= `load_data`, then `count`++.
  - `load_en` && `full`: ignored; no write, `count` unchanged.
  - `start` && `count` > 0: go to RUN, `pc` <= 0.
  - `start` && `count` == 0: go directly to DONE; `done` <= 1.
  - `start` and `load_en` in the same cycle: `start` wins and the load is dropped.
- RUN:
  - !`stall`: `instructionIF` <= `buf[pc]`, `valid` <= 1, `pc` <= `pc`+1.
  - When the issued address equals `count`-1, next state is DONE.
  - `stall`: `instructionIF`, `valid`, `pc` and state all hold.
  - `load_en` and `start` are ignored in RUN.
- DONE:
  - `instructionIF` <= NOP, `valid` <= 0, `done` <= 1, `pc` holds at `count` (wraps to 0 when `count` == DEPTH).
  - `start`: restart the same program. `done` <= 0, `pc` <= 0, go to RUN; `count` is retained.
  - `load_en`: begin a new program. `buf[0]` <= `load_data`, `count` <= 1, `done` <= 0, go to IDLE.
  - `start` and `load_en` together: `start` wins.
  - `stall` is ignored.
- Arithmetic: `count` saturates at DEPTH. `pc` is a modulo-DEPTH counter, but it never wraps within RUN.
- Reset asserted mid-RUN: all outputs return to their reset values on the next edge and `count` is cleared (the program must be reloaded). No partial issue follows reset.

## Timing
- Load: a word written on edge N is readable for issue from edge N+1 onward. `count` and `full` update on edge N.
- Issue latency: with `start` sampled on edge S, the first instruction and `valid` = 1 appear after edge S+1. Instruction k appears after edge S+1+k plus the number of stall cycles.
- Stall: `stall` high at edge E means the outputs after E equal the outputs before E.
- Completion: the last instruction stays on the output for one cycle, or longer under stall. On the next non-stalled edge, `instructionIF` becomes NOP, `valid` becomes 0 and `done` becomes 1, all together.
- `done` stays high until `start`, `load_en` (in DONE) or `reset`.

## Test plan
- **Reset defaults:** assert `reset` for 2 cycles with random inputs -> `instructionIF` = 25'h1800000, `valid` = 0, `pc` = 0, `count` = 0, `done` = 0.
- **Basic load and issue:**
  - Stimulus: load 25'h184b02d, 25'h0000001, 25'h1ffffff; pulse `start`.
  - Response: over the 3 cycles after the start edge `instructionIF` shows those words in order with `valid` = 1 and `pc` = 1, 2, 3; on the next cycle NOP, `valid` = 0, `done` = 1.
- **Stall:**
  - Stimulus: same program; hold `stall` high for 3 cycles while the second instruction is on the output.
  - Response: 25'h0000001 is held for 4 cycles total with `pc` frozen at 2; the sequence then resumes and `done` arrives 3 cycles later than in the basic case.
- **Full buffer:**
  - Stimulus: load 64 words (value = index), then attempt a 65th load of 25'h1555555; pulse `start`.
  - Response: `full` = 1 and `count` = 64, and the extra load is dropped. The 64 words issue as 0..63, then `done` = 1 with `pc` wrapped to 0.
- **Empty start and priority:**
  - Stimulus: `start` with `count` = 0; then, in DONE, assert `start` and `load_en` in the same cycle.
  - Response: first `done` = 1 one cycle after `start` with `valid` never set; then `start` wins, the load is ignored and `count` stays 0.
- **Restart, reload, mid-run reset:**
  - Restart: after `done`, pulse `start` -> the same program re-issues from `pc` 0.
  - Reload: after `done`, `load_en` with 25'h0abcdef -> IDLE with `count` = 1 and `done` = 0.
  - Mid-run reset: assert `reset` during RUN -> all reset values on the next edge, `count` = 0.
